// File: rtl/c3aibadapt_cmn_occ_pkg.sv
// Shared types and limits for the OCC capture scheduler.
package c3aibadapt_cmn_occ_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SE_FALL = 3'd1,
    ST_PULSE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_SE_RISE = 3'd4,
    ST_DONE    = 3'd5
  } occ_state_e;

  // Width of each per-domain burst count field.
  localparam int BURST_W = 2;

  // scan_enable must settle for at least one cycle around a window.
  localparam int MIN_SETTLE = 1;

  // 3-flop synchroniser plus a maximum burst of 3 plus margin.
  localparam int MIN_WAIT_CYC = 8;

endpackage

// File: rtl/c3aibadapt_cmn_occ_capture_sched_rr_pick.sv
// Combinational round-robin picker: first set mask bit at or after rr_ptr_i,
// wrapping modulo NUM_DOM.
module c3aibadapt_cmn_occ_rr_pick #(
  parameter int NUM_DOM = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_DOM-1:0] mask_i,
  input  logic [IW-1:0]      rr_ptr_i,
  output logic [NUM_DOM-1:0] grant_o,
  output logic [IW-1:0]      idx_o,
  output logic               rem_nz_o
);

  logic found;

  // Scan domains starting at the pointer and grant the first requester.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_DOM; i++) begin
      if (!found && mask_i[(int'(rr_ptr_i) + i) % NUM_DOM]) begin
        found = 1'b1;
        grant_o[(int'(rr_ptr_i) + i) % NUM_DOM] = 1'b1;
        idx_o = IW'((int'(rr_ptr_i) + i) % NUM_DOM);
      end
    end
  end

  // Anything left to serve once the granted domain is removed.
  assign rem_nz_o = |(mask_i & ~grant_o);

endmodule

// File: rtl/c3aibadapt_cmn_occ_capture_sched.sv
// ATPG capture scheduler: drops scan_enable, fires the OCC triggers, waits
// out the synchroniser/burst window and restores shift mode.
module c3aibadapt_cmn_occ_capture_sched
  import c3aibadapt_cmn_occ_pkg::*;
#(
  parameter int NUM_DOM  = 4,
  parameter int SETTLE   = 4,
  parameter int WAIT_CYC = 16,
  parameter int CW       = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       atpg_mode,
  input  logic                       cap_req,
  input  logic [NUM_DOM-1:0]         cap_mask,
  input  logic                       serial_mode,
  input  logic [BURST_W*NUM_DOM-1:0] burst_cfg,
  output logic                       scan_enable,
  output logic [NUM_DOM-1:0]         occ_enable,
  output logic [BURST_W*NUM_DOM-1:0] burst_cnt,
  output logic                       busy,
  output logic                       cap_ack,
  output logic                       abort
);

  localparam int IW = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

  if (SETTLE < MIN_SETTLE) begin : g_bad_settle
    $error("SETTLE below minimum");
  end
  if (WAIT_CYC < MIN_WAIT_CYC) begin : g_bad_wait
    $error("WAIT_CYC below minimum");
  end
  if ((SETTLE >= (1 << CW)) || (WAIT_CYC >= (1 << CW))) begin : g_bad_cw
    $error("CW too narrow for SETTLE/WAIT_CYC");
  end

  occ_state_e                 state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       scan_q, scan_d;
  logic [NUM_DOM-1:0]         occ_q, occ_d;
  logic [BURST_W*NUM_DOM-1:0] burst_q, burst_d;
  logic                       busy_q, busy_d;
  logic                       ack_q, ack_d;
  logic                       abort_q, abort_d;
  logic [IW-1:0]              rr_q, rr_d;
  // Sequence context: only meaningful after an accept, so left unreset.
  logic [NUM_DOM-1:0]         mask_q, mask_d;
  logic                       serial_q, serial_d;
  logic [IW-1:0]              sel_q, sel_d;

  logic [NUM_DOM-1:0]         grant;
  logic [IW-1:0]              gidx;
  logic                       rem_nz;

  c3aibadapt_cmn_occ_rr_pick #(
    .NUM_DOM (NUM_DOM),
    .IW      (IW)
  ) u_rr_pick (
    .mask_i   (mask_q),
    .rr_ptr_i (rr_q),
    .grant_o  (grant),
    .idx_o    (gidx),
    .rem_nz_o (rem_nz)
  );

  // Next-state and registered-output logic; loss of atpg_mode aborts any
  // sequence in flight and returns the scan chain to shift mode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    scan_d   = scan_q;
    occ_d    = '0;
    burst_d  = burst_q;
    busy_d   = busy_q;
    ack_d    = 1'b0;
    abort_d  = 1'b0;
    rr_d     = rr_q;
    mask_d   = mask_q;
    serial_d = serial_q;
    sel_d    = sel_q;
    if ((state_q != ST_IDLE) && !atpg_mode) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      scan_d  = 1'b1;
      busy_d  = 1'b0;
      abort_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d  = '0;
          busy_d = 1'b0;
          if (cap_req && atpg_mode) begin
            mask_d   = cap_mask;
            serial_d = serial_mode;
            burst_d  = burst_cfg;
            busy_d   = 1'b1;
            if (cap_mask == '0) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_SE_FALL;
              scan_d  = 1'b0;
            end
          end
        end
        ST_SE_FALL: begin
          if (cnt_q == CW'(SETTLE - 1)) begin
            state_d = ST_PULSE;
            cnt_d   = '0;
            occ_d   = serial_q ? grant : mask_q;
            sel_d   = gidx;
          end
        end
        ST_PULSE: begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
        ST_WAIT: begin
          if (cnt_q == CW'(WAIT_CYC - 1)) begin
            state_d = ST_SE_RISE;
            cnt_d   = '0;
            scan_d  = 1'b1;
          end
        end
        ST_SE_RISE: begin
          if (cnt_q == CW'(SETTLE - 1)) begin
            cnt_d = '0;
            if (serial_q) begin
              // Retire the served domain and move the pointer past it.
              mask_d = mask_q & ~grant;
              rr_d   = (sel_q == IW'(NUM_DOM - 1)) ? '0 : sel_q + IW'(1);
              if (rem_nz) begin
                state_d = ST_SE_FALL;
                scan_d  = 1'b0;
              end else begin
                state_d = ST_DONE;
              end
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          ack_d   = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Control and output registers; reset wins over abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      scan_q  <= 1'b1;
      occ_q   <= '0;
      burst_q <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      abort_q <= 1'b0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      scan_q  <= scan_d;
      occ_q   <= occ_d;
      burst_q <= burst_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      abort_q <= abort_d;
      rr_q    <= rr_d;
    end
  end

  // Sequence context captured on accept and updated per serial window.
  always_ff @(posedge clk) begin
    mask_q   <= mask_d;
    serial_q <= serial_d;
    sel_q    <= sel_d;
  end

  assign scan_enable = scan_q;
  assign occ_enable  = occ_q;
  assign burst_cnt   = burst_q;
  assign busy        = busy_q;
  assign cap_ack     = ack_q;
  assign abort       = abort_q;

endmodule

// File: tb/tb_c3aibadapt_cmn_occ_capture_sched.sv
// Directed bench for the OCC capture scheduler (default parameters).
module tb_c3aibadapt_cmn_occ_capture_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       atpg_mode = 1'b0;
  logic       cap_req = 1'b0;
  logic [3:0] cap_mask = '0;
  logic       serial_mode = 1'b0;
  logic [7:0] burst_cfg = '0;
  logic       scan_enable;
  logic [3:0] occ_enable;
  logic [7:0] burst_cnt;
  logic       busy;
  logic       cap_ack;
  logic       abort;

  int n_cmp  = 0;
  int n_fail = 0;

  logic       s_scan  [128];
  logic [3:0] s_occ   [128];
  logic [7:0] s_burst [128];
  logic       s_busy  [128];
  logic       s_ack   [128];
  logic       s_abort [128];

  c3aibadapt_cmn_occ_capture_sched dut (
    .clk         (clk),
    .rst         (rst),
    .atpg_mode   (atpg_mode),
    .cap_req     (cap_req),
    .cap_mask    (cap_mask),
    .serial_mode (serial_mode),
    .burst_cfg   (burst_cfg),
    .scan_enable (scan_enable),
    .occ_enable  (occ_enable),
    .burst_cnt   (burst_cnt),
    .busy        (busy),
    .cap_ack     (cap_ack),
    .abort       (abort)
  );

  always #5 clk = ~clk;

  // Present a capture request for the next rising edge (the accept edge).
  task automatic issue(input logic [3:0] m, input logic ser, input logic [7:0] b);
    @(negedge clk);
    cap_req     = 1'b1;
    cap_mask    = m;
    serial_mode = ser;
    burst_cfg   = b;
  endtask

  // Sample index k holds outputs after accept edge + k; optionally pulse
  // cap_req again (with mask im) right after samples ia / ib.
  task automatic record(input int n, input int ia, input int ib, input logic [3:0] im);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      s_scan[k]  = scan_enable;
      s_occ[k]   = occ_enable;
      s_burst[k] = burst_cnt;
      s_busy[k]  = busy;
      s_ack[k]   = cap_ack;
      s_abort[k] = abort;
      cap_req    = (k == ia) || (k == ib);
      if ((k == ia) || (k == ib)) cap_mask = im;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (scan_enable !== 1'b1) begin n_fail++; $display("FAIL reset_scan got %b exp 1", scan_enable); end
    n_cmp++; if (occ_enable !== 4'h0) begin n_fail++; $display("FAIL reset_occ got %h exp 0", occ_enable); end
    n_cmp++; if (burst_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_burst got %h exp 00", burst_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_cmp++; if (cap_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b exp 0", cap_ack); end
    n_cmp++; if (abort !== 1'b0) begin n_fail++; $display("FAIL reset_abort got %b exp 0", abort); end
  endtask

  task automatic test_idle_ignore;
    atpg_mode = 1'b0;
    for (int k = 0; k < 50; k++) begin
      cap_req = 1'b1; cap_mask = 4'hF; burst_cfg = 8'hAA;
      @(negedge clk);
      n_cmp++; if (scan_enable !== 1'b1 || busy !== 1'b0 || occ_enable !== 4'h0 || burst_cnt !== 8'h00 || cap_ack !== 1'b0)
        begin n_fail++; $display("FAIL idle_ignore k=%0d got se=%b busy=%b occ=%h burst=%h ack=%b", k, scan_enable, busy, occ_enable, burst_cnt, cap_ack); end
    end
    cap_req = 1'b0;
    atpg_mode = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_parallel;
    issue(4'b0101, 1'b0, 8'hE4);
    record(32, -1, -1, 4'h0);
    for (int k = 0; k < 32; k++) begin
      n_cmp++; if (s_scan[k] !== (k >= 21)) begin n_fail++; $display("FAIL par_scan k=%0d got %b exp %b", k, s_scan[k], (k >= 21)); end
      n_cmp++; if (s_occ[k] !== ((k == 4) ? 4'b0101 : 4'b0000)) begin n_fail++; $display("FAIL par_occ k=%0d got %h", k, s_occ[k]); end
      n_cmp++; if (s_ack[k] !== (k == 26)) begin n_fail++; $display("FAIL par_ack k=%0d got %b exp %b", k, s_ack[k], (k == 26)); end
      n_cmp++; if (s_busy[k] !== (k <= 26)) begin n_fail++; $display("FAIL par_busy k=%0d got %b exp %b", k, s_busy[k], (k <= 26)); end
      n_cmp++; if (s_burst[k] !== 8'hE4) begin n_fail++; $display("FAIL par_burst k=%0d got %h exp e4", k, s_burst[k]); end
      n_cmp++; if (s_abort[k] !== 1'b0) begin n_fail++; $display("FAIL par_abort k=%0d got %b exp 0", k, s_abort[k]); end
    end
  endtask

  task automatic test_serial_rr;
    logic exp_se;
    issue(4'b1010, 1'b1, 8'h1B);
    record(55, -1, -1, 4'h0);
    for (int k = 0; k < 55; k++) begin
      exp_se = !((k <= 20) || (k >= 25 && k <= 45));
      n_cmp++; if (s_scan[k] !== exp_se) begin n_fail++; $display("FAIL ser_scan k=%0d got %b exp %b", k, s_scan[k], exp_se); end
      n_cmp++; if (s_occ[k] !== ((k == 4) ? 4'b0010 : (k == 29) ? 4'b1000 : 4'b0000))
        begin n_fail++; $display("FAIL ser_occ k=%0d got %h", k, s_occ[k]); end
      n_cmp++; if (s_ack[k] !== (k == 51)) begin n_fail++; $display("FAIL ser_ack k=%0d got %b exp %b", k, s_ack[k], (k == 51)); end
      n_cmp++; if (s_busy[k] !== (k <= 51)) begin n_fail++; $display("FAIL ser_busy k=%0d got %b exp %b", k, s_busy[k], (k <= 51)); end
      n_cmp++; if (s_burst[k] !== 8'h1B) begin n_fail++; $display("FAIL ser_burst k=%0d got %h exp 1b", k, s_burst[k]); end
    end
    // Pointer wrapped back to 0, so domain 0 goes first.
    issue(4'b0011, 1'b1, 8'h1B);
    record(55, -1, -1, 4'h0);
    for (int k = 0; k < 55; k++) begin
      n_cmp++; if (s_occ[k] !== ((k == 4) ? 4'b0001 : (k == 29) ? 4'b0010 : 4'b0000))
        begin n_fail++; $display("FAIL ser2_occ k=%0d got %h", k, s_occ[k]); end
      n_cmp++; if (s_ack[k] !== (k == 51)) begin n_fail++; $display("FAIL ser2_ack k=%0d got %b exp %b", k, s_ack[k], (k == 51)); end
    end
  endtask

  task automatic test_rr_persist;
    // Serial on domain 2 leaves the pointer at 3.
    issue(4'b0100, 1'b1, 8'h00);
    record(30, -1, -1, 4'h0);
    n_cmp++; if (s_occ[4] !== 4'b0100) begin n_fail++; $display("FAIL rr_single_occ got %h exp 4", s_occ[4]); end
    n_cmp++; if (s_ack[26] !== 1'b1) begin n_fail++; $display("FAIL rr_single_ack got %b exp 1", s_ack[26]); end
    // A parallel sequence must leave the pointer alone.
    issue(4'b0001, 1'b0, 8'h00);
    record(30, -1, -1, 4'h0);
    n_cmp++; if (s_occ[4] !== 4'b0001) begin n_fail++; $display("FAIL rr_par_occ got %h exp 1", s_occ[4]); end
    n_cmp++; if (s_ack[26] !== 1'b1) begin n_fail++; $display("FAIL rr_par_ack got %b exp 1", s_ack[26]); end
    issue(4'b1001, 1'b1, 8'h00);
    record(55, -1, -1, 4'h0);
    n_cmp++; if (s_occ[4] !== 4'b1000) begin n_fail++; $display("FAIL rr_persist_first got %h exp 8", s_occ[4]); end
    n_cmp++; if (s_occ[29] !== 4'b0001) begin n_fail++; $display("FAIL rr_persist_second got %h exp 1", s_occ[29]); end
    n_cmp++; if (s_ack[51] !== 1'b1) begin n_fail++; $display("FAIL rr_persist_ack got %b exp 1", s_ack[51]); end
  endtask

  task automatic test_empty_mask;
    issue(4'b0000, 1'b0, 8'h5A);
    record(6, -1, -1, 4'h0);
    for (int k = 0; k < 6; k++) begin
      n_cmp++; if (s_scan[k] !== 1'b1) begin n_fail++; $display("FAIL empty_scan k=%0d got %b exp 1", k, s_scan[k]); end
      n_cmp++; if (s_occ[k] !== 4'h0) begin n_fail++; $display("FAIL empty_occ k=%0d got %h exp 0", k, s_occ[k]); end
      n_cmp++; if (s_ack[k] !== (k == 1)) begin n_fail++; $display("FAIL empty_ack k=%0d got %b exp %b", k, s_ack[k], (k == 1)); end
      n_cmp++; if (s_busy[k] !== (k <= 1)) begin n_fail++; $display("FAIL empty_busy k=%0d got %b exp %b", k, s_busy[k], (k <= 1)); end
      n_cmp++; if (s_burst[k] !== 8'h5A) begin n_fail++; $display("FAIL empty_burst k=%0d got %h exp 5a", k, s_burst[k]); end
    end
  endtask

  task automatic test_abort;
    issue(4'b1111, 1'b0, 8'h00);
    record(10, -1, -1, 4'h0);
    n_cmp++; if (s_scan[9] !== 1'b0) begin n_fail++; $display("FAIL abort_pre_scan got %b exp 0", s_scan[9]); end
    atpg_mode = 1'b0;
    @(negedge clk);
    n_cmp++; if (scan_enable !== 1'b1) begin n_fail++; $display("FAIL abort_scan got %b exp 1", scan_enable); end
    n_cmp++; if (abort !== 1'b1) begin n_fail++; $display("FAIL abort_pulse got %b exp 1", abort); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b exp 0", busy); end
    n_cmp++; if (occ_enable !== 4'h0) begin n_fail++; $display("FAIL abort_occ got %h exp 0", occ_enable); end
    n_cmp++; if (cap_ack !== 1'b0) begin n_fail++; $display("FAIL abort_ack got %b exp 0", cap_ack); end
    atpg_mode = 1'b1;
    record(30, -1, -1, 4'h0);
    for (int k = 0; k < 30; k++) begin
      n_cmp++; if (s_ack[k] !== 1'b0 || s_abort[k] !== 1'b0 || s_scan[k] !== 1'b1 || s_busy[k] !== 1'b0)
        begin n_fail++; $display("FAIL abort_after k=%0d got ack=%b abort=%b se=%b busy=%b", k, s_ack[k], s_abort[k], s_scan[k], s_busy[k]); end
    end
    issue(4'b0010, 1'b0, 8'h33);
    record(30, -1, -1, 4'h0);
    n_cmp++; if (s_occ[4] !== 4'b0010) begin n_fail++; $display("FAIL abort_retry_occ got %h exp 2", s_occ[4]); end
    n_cmp++; if (s_ack[26] !== 1'b1) begin n_fail++; $display("FAIL abort_retry_ack got %b exp 1", s_ack[26]); end
  endtask

  task automatic test_busy_collision;
    issue(4'b0001, 1'b0, 8'hC3);
    record(42, 2, 10, 4'b1111);
    for (int k = 0; k < 42; k++) begin
      n_cmp++; if (s_occ[k] !== ((k == 4) ? 4'b0001 : 4'b0000)) begin n_fail++; $display("FAIL coll_occ k=%0d got %h", k, s_occ[k]); end
      n_cmp++; if (s_ack[k] !== (k == 26)) begin n_fail++; $display("FAIL coll_ack k=%0d got %b exp %b", k, s_ack[k], (k == 26)); end
      n_cmp++; if (s_scan[k] !== (k >= 21)) begin n_fail++; $display("FAIL coll_scan k=%0d got %b exp %b", k, s_scan[k], (k >= 21)); end
      n_cmp++; if (s_burst[k] !== 8'hC3) begin n_fail++; $display("FAIL coll_burst k=%0d got %h exp c3", k, s_burst[k]); end
    end
  endtask

  task automatic test_rst_in_pulse;
    issue(4'b0110, 1'b0, 8'hFF);
    record(5, -1, -1, 4'h0);
    n_cmp++; if (s_occ[4] !== 4'b0110) begin n_fail++; $display("FAIL rst_pre_occ got %h exp 6", s_occ[4]); end
    // Dropping atpg_mode in the same cycle checks that reset beats abort.
    rst = 1'b1;
    atpg_mode = 1'b0;
    @(negedge clk);
    n_cmp++; if (scan_enable !== 1'b1) begin n_fail++; $display("FAIL rst_scan got %b exp 1", scan_enable); end
    n_cmp++; if (occ_enable !== 4'h0) begin n_fail++; $display("FAIL rst_occ got %h exp 0", occ_enable); end
    n_cmp++; if (burst_cnt !== 8'h00) begin n_fail++; $display("FAIL rst_burst got %h exp 00", burst_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_cmp++; if (cap_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack got %b exp 0", cap_ack); end
    n_cmp++; if (abort !== 1'b0) begin n_fail++; $display("FAIL rst_abort got %b exp 0", abort); end
    rst = 1'b0;
    atpg_mode = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_parallel();
    test_serial_rr();
    test_rr_persist();
    test_empty_mask();
    test_abort();
    test_busy_collision();
    test_rst_in_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
